// File: rtl/mul_shift_pkg.sv
// Shared constants for the multi-cycle MUL / shift sequencer: opcodes,
// FSM state encoding, datapath width and the shift iteration-count rule.
package mul_shift_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Iteration count for shift/rotate opcodes; MUL is handled by the caller
  // because its count is a module parameter. Invalid opcodes need no steps.
  function automatic logic [CNT_W-1:0] shift_steps(input logic [2:0] op,
                                                   input logic [3:0] amt);
    logic [CNT_W-1:0] n;
    n = 4'd0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: n = amt[3] ? 4'd8 : amt;
      OP_ROR:                 n = {1'b0, amt[2:0]};
      default:                n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mul_shift_step.sv
// One iteration of the serial datapath: a shift-and-add multiply step or a
// single-bit shift/rotate. Purely combinational; the sequencer owns all state.
module mul_shift_step
  import mul_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] v_nxt_o,
  output logic [WIDTH-1:0] acc_nxt_o,
  output logic [WIDTH-1:0] mcand_nxt_o,
  output logic [WIDTH-1:0] mplier_nxt_o
);

  // Next-value computation for a single step of the selected operation.
  always_comb begin
    v_nxt_o      = v_i;
    acc_nxt_o    = acc_i;
    mcand_nxt_o  = mcand_i;
    mplier_nxt_o = mplier_i;
    case (op_i)
      OP_MUL: begin
        if (mplier_i[0]) begin
          acc_nxt_o = acc_i + mcand_i;
        end else begin
          acc_nxt_o = acc_i;
        end
        mcand_nxt_o  = {mcand_i[WIDTH-2:0], 1'b0};
        mplier_nxt_o = {1'b0, mplier_i[WIDTH-1:1]};
      end
      OP_SLL:  v_nxt_o = {v_i[WIDTH-2:0], 1'b0};
      OP_SRL:  v_nxt_o = {1'b0, v_i[WIDTH-1:1]};
      OP_SRA:  v_nxt_o = {sign_i, v_i[WIDTH-1:1]};
      OP_ROR:  v_nxt_o = {v_i[0], v_i[WIDTH-1:1]};
      default: v_nxt_o = v_i;
    endcase
  end

endmodule

// File: rtl/mul_shift_seq.sv
// Multi-cycle MUL / shift / rotate sequencer. Accepts one operation via
// START when idle or finishing, iterates one bit per cycle in RUN and
// presents RESULT with a one-cycle DONE pulse in FIN. STALL freezes the
// pipeline from the accept cycle until the last RUN cycle.
module mul_shift_seq
  import mul_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MUL_STEPS = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             STALL
);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       op_q,     op_d;
  logic [WIDTH-1:0] v_q,      v_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sign_q,   sign_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accepting_s;
  logic             accept_s;
  logic [CNT_W-1:0] steps_s;
  logic [WIDTH-1:0] v_nxt_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] mcand_nxt_s;
  logic [WIDTH-1:0] mplier_nxt_s;

  mul_shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i         (op_q),
    .v_i          (v_q),
    .acc_i        (acc_q),
    .mcand_i      (mcand_q),
    .mplier_i     (mplier_q),
    .sign_i       (sign_q),
    .v_nxt_o      (v_nxt_s),
    .acc_nxt_o    (acc_nxt_s),
    .mcand_nxt_o  (mcand_nxt_s),
    .mplier_nxt_o (mplier_nxt_s)
  );

  assign accepting_s = (state_q == ST_IDLE) || (state_q == ST_FIN);
  assign accept_s    = START && accepting_s;
  assign steps_s     = (OPCODE == OP_MUL) ? MUL_STEPS[CNT_W-1:0]
                                          : shift_steps(OPCODE, DATA2[3:0]);

  // Next-state logic: accept/launch, per-cycle iteration, result capture on FIN entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    v_d      = v_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      ST_RUN: begin
        v_d      = v_nxt_s;
        acc_d    = acc_nxt_s;
        mcand_d  = mcand_nxt_s;
        mplier_d = mplier_nxt_s;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = ST_FIN;
          result_d = (op_q == OP_MUL) ? acc_nxt_s : v_nxt_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_IDLE, ST_FIN: begin
        if (accept_s) begin
          op_d     = OPCODE;
          v_d      = DATA1;
          acc_d    = {WIDTH{1'b0}};
          mcand_d  = DATA1;
          mplier_d = DATA2;
          sign_d   = DATA1[WIDTH-1];
          cnt_d    = steps_s;
          if (steps_s != 4'd0) begin
            state_d = ST_RUN;
          end else begin
            // Zero-step operations (shift by 0, ROR by 8, invalid) return DATA1.
            state_d  = ST_FIN;
            result_d = DATA1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that discards any in-flight op.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 3'b000;
      v_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      sign_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);
  assign RESULT = result_q;
  assign STALL  = (accept_s && (steps_s != 4'd0)) || BUSY;

endmodule
